// File: rtl/root_pkg.sv
// Shared constants and types for the iterative N-th root unit.
package root_pkg;
  localparam int DATA_W  = 10;
  localparam int ORDER_W = 3;
  localparam int OUT_W   = 2 * DATA_W;
  localparam int ACC_W   = DATA_W + 1;
  localparam int PROD_W  = ACC_W + DATA_W;
  localparam int BIT_W   = $clog2(DATA_W);

  localparam logic [ACC_W-1:0] SAT_VAL  = ACC_W'(1024);
  localparam logic [OUT_W-1:0] ERR_CODE = {OUT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, POW, CMP, DONE, ERR} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] root;
    logic [DATA_W-1:0] rem;
  } result_t;
endpackage

// File: rtl/sat_mul_11x10.sv
// Combinational acc*cand with saturation: any product above the radicand range becomes SAT_VAL.
module sat_mul_11x10
  import root_pkg::*;
(
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  p
);
  logic [PROD_W-1:0] prod;

  assign prod = PROD_W'(a) * PROD_W'(b);
  // SAT_VAL is sticky: 1024 times any non-zero candidate stays at or above 1024
  assign p = (prod >= PROD_W'(SAT_VAL)) ? SAT_VAL : prod[ACC_W-1:0];
endmodule

// File: rtl/nth_root_engine.sv
// Bit-serial floor(X^(1/N)) search: per result bit, raise the candidate to N by repeated
// saturating multiply, then keep the bit if the power does not exceed X.
module nth_root_engine
  import root_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data_1,
  input  logic [ORDER_W-1:0] in_data_2,
  output logic               busy,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data
);
  state_t              state, state_nxt;
  logic [DATA_W-1:0]   x_q, root_q, cand_q, pow_ok_q, root_nxt;
  logic [ORDER_W-1:0]  n_q, cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic [ACC_W-1:0]    acc_q, prod;
  logic                hit;
  result_t             res;

  sat_mul_11x10 u_mul (.a(acc_q), .b(cand_q), .p(prod));

  assign hit      = (acc_q <= {1'b0, x_q});
  assign root_nxt = hit ? cand_q : root_q;
  assign busy     = (state != IDLE);
  assign res      = '{root: root_q, rem: x_q - pow_ok_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = (in_data_2 == '0) ? ERR : POW;
      POW:      if (cnt_q + ORDER_W'(1) == n_q) state_nxt = CMP;
      CMP:      state_nxt = (bit_q == '0) ? DONE : POW;
      DONE:     state_nxt = IDLE;
      ERR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      n_q       <= '0;
      root_q    <= '0;
      cand_q    <= '0;
      pow_ok_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          x_q      <= in_data_1;
          n_q      <= in_data_2;
          root_q   <= '0;
          bit_q    <= BIT_W'(DATA_W - 1);
          cand_q   <= DATA_W'(1) << (DATA_W - 1);
          acc_q    <= ACC_W'(1);
          cnt_q    <= '0;
          pow_ok_q <= '0;
        end
        POW: begin
          acc_q <= prod;
          cnt_q <= cnt_q + ORDER_W'(1);
        end
        CMP: begin
          root_q <= root_nxt;
          // remember the power of the accepted candidate so the remainder needs no extra pass
          if (hit) pow_ok_q <= acc_q[DATA_W-1:0];
          if (bit_q != '0) begin
            bit_q  <= bit_q - BIT_W'(1);
            cand_q <= root_nxt | (DATA_W'(1) << (bit_q - BIT_W'(1)));
            acc_q  <= ACC_W'(1);
            cnt_q  <= '0;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          out_data  <= res;
        end
        ERR: begin
          out_valid <= 1'b1;
          out_data  <= ERR_CODE;
        end
        default: ;
      endcase
    end
  end
endmodule
